// File: rtl/ram_sdp_be.sv
// Simple-dual-port synchronous RAM with byte write enables and write-first bypass.
// It has a read latency of 1 or 2 and zero-fills itself after reset.
module ram_sdp_be #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wena,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  rena,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("ram_sdp_be: RD_LAT must be 1 or 2");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_width
            $error("ram_sdp_be: DATA_W must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    // Unified write port: the clear sweep and user writes share it.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [NB-1:0]     mem_wbe;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_accept;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] data_out_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_word;
    logic              bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_we     = 1'b0;
        mem_waddr  = waddr;
        mem_wbe    = wbe;
        mem_wdata  = data_in;
        rd_accept  = 1'b0;
        case (state_reg)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_reg;
                mem_wbe   = '1;
                mem_wdata = '0;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == {ADDR_W{1'b1}}) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                mem_we    = ena & wena;
                rd_accept = ena & rena;
            end
            default: begin
                state_next = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we && mem_wbe[b]) begin
                mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Write-first: bytes being written this cycle to the read address win over the array.
    assign bypass = mem_we && (mem_waddr == raddr);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_merge
            assign rd_word[8*gi +: 8] = (bypass && mem_wbe[gi]) ? mem_wdata[8*gi +: 8]
                                                                : mem[raddr][8*gi +: 8];
        end
    endgenerate

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_reg <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_accept;
                    if (rd_accept) begin
                        data_out_reg <= rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic [DATA_W-1:0] s1_data_reg;
            logic              s1_valid_reg;

            // Second stage is not gated by ena so accepted reads always drain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_data_reg  <= '0;
                    s1_valid_reg <= 1'b0;
                    data_out_reg <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    s1_valid_reg <= rd_accept;
                    if (rd_accept) begin
                        s1_data_reg <= rd_word;
                    end
                    rd_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        data_out_reg <= s1_data_reg;
                    end
                end
            end
        end
    endgenerate

    assign data_out  = data_out_reg;
    assign rd_valid  = rd_valid_reg;
    assign init_busy = (state_reg == ST_INIT);

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: one latency-1 and one latency-2 instance share the same stimulus.
module tb_ram_sdp_be;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wena;
    logic [4:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] data_in;
    logic        rena;
    logic [4:0]  raddr;
    logic [31:0] data_out1;
    logic        rd_valid1;
    logic        init_busy1;
    logic [31:0] data_out2;
    logic        rd_valid2;
    logic        init_busy2;

    int n_cmp;
    int n_bad;

    ram_sdp_be #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .waddr(waddr), .wbe(wbe),
        .data_in(data_in), .rena(rena), .raddr(raddr), .data_out(data_out1),
        .rd_valid(rd_valid1), .init_busy(init_busy1)
    );

    ram_sdp_be #(.DATA_W(32), .ADDR_W(5), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .waddr(waddr), .wbe(wbe),
        .data_in(data_in), .rena(rena), .raddr(raddr), .data_out(data_out2),
        .rd_valid(rd_valid2), .init_busy(init_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        ena = 1'b1; wena = 1'b1; waddr = a; data_in = d; wbe = be;
        step();
        wena = 1'b0;
    endtask

    // Reads one address and checks both latencies against the same expected word.
    task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
        ena = 1'b1; rena = 1'b1; raddr = a;
        step();
        rena = 1'b0;
        chk({tag, " v1"}, {31'd0, rd_valid1}, 32'd1);
        chk({tag, " d1"}, data_out1, exp);
        chk({tag, " v2 early"}, {31'd0, rd_valid2}, 32'd0);
        step();
        chk({tag, " v1 drop"}, {31'd0, rd_valid1}, 32'd0);
        chk({tag, " v2"}, {31'd0, rd_valid2}, 32'd1);
        chk({tag, " d2"}, data_out2, exp);
    endtask

    // Counts cycles until both instances leave the sweep; flags any rd_valid seen meanwhile.
    task automatic wait_init(input string tag);
        int cycles;
        bit saw_valid;
        cycles = 0;
        saw_valid = 1'b0;
        while ((init_busy1 || init_busy2) && cycles < 100) begin
            step();
            cycles++;
            if (rd_valid1 || rd_valid2) saw_valid = 1'b1;
        end
        rena = 1'b0;
        chk({tag, " init cycles"}, 32'(cycles), 32'd32);
        chk({tag, " no valid in init"}, {31'd0, saw_valid}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; ena = 1'b0; wena = 1'b0; waddr = '0; wbe = '0;
        data_in = '0; rena = 1'b0; raddr = '0;
        step();
        step();
        chk("reset data_out1", data_out1, 32'h0);
        chk("reset data_out2", data_out2, 32'h0);
        chk("reset rd_valid", {30'd0, rd_valid1, rd_valid2}, 32'd0);
        chk("reset init_busy", {30'd0, init_busy1, init_busy2}, 32'd3);

        // Sweep with a pending read of addr 31 and a write of addr 31 that must both be ignored.
        rst_n = 1'b1;
        ena = 1'b1; rena = 1'b1; raddr = 5'd31;
        wena = 1'b1; waddr = 5'd31; data_in = 32'hFFFF_FFFF; wbe = 4'hF;
        wait_init("sweep");
        wena = 1'b0;
        do_read("post-init a31", 5'd31, 32'h0000_0000);

        // Byte enables
        do_write(5'd5, 32'hAABB_CCDD, 4'b1111);
        do_write(5'd5, 32'h1122_3344, 4'b0101);
        do_read("byte-en a5", 5'd5, 32'hAA22_CC44);

        // Write-first bypass, then confirm the array holds the merged word
        do_write(5'd7, 32'h0123_4567, 4'b1111);
        ena = 1'b1; wena = 1'b1; waddr = 5'd7; data_in = 32'hDEAD_BEEF; wbe = 4'b1100;
        rena = 1'b1; raddr = 5'd7;
        step();
        wena = 1'b0; rena = 1'b0;
        chk("bypass v1", {31'd0, rd_valid1}, 32'd1);
        chk("bypass d1", data_out1, 32'hDEAD_4567);
        step();
        chk("bypass d2", data_out2, 32'hDEAD_4567);
        do_read("bypass stored a7", 5'd7, 32'hDEAD_4567);

        // Enable gating
        do_write(5'd3, 32'h3333_3333, 4'b1111);
        ena = 1'b0; wena = 1'b1; waddr = 5'd3; data_in = 32'hFFFF_FFFF; wbe = 4'hF;
        step();
        wena = 1'b0; rena = 1'b1; raddr = 5'd3;
        step();
        rena = 1'b0;
        chk("gated read v1", {31'd0, rd_valid1}, 32'd0);
        step();
        chk("gated read v2", {31'd0, rd_valid2}, 32'd0);
        do_read("gated write a3", 5'd3, 32'h3333_3333);

        // Streaming reads; ena drops after the last request
        do_write(5'd0, 32'h10, 4'hF);
        do_write(5'd1, 32'h11, 4'hF);
        do_write(5'd2, 32'h12, 4'hF);
        ena = 1'b1; rena = 1'b1; raddr = 5'd0;
        step();
        raddr = 5'd1;
        chk("stream e1 v1", {31'd0, rd_valid1}, 32'd1);
        chk("stream e1 d1", data_out1, 32'h10);
        chk("stream e1 v2", {31'd0, rd_valid2}, 32'd0);
        step();
        raddr = 5'd2;
        chk("stream e2 d1", data_out1, 32'h11);
        chk("stream e2 v2", {31'd0, rd_valid2}, 32'd1);
        chk("stream e2 d2", data_out2, 32'h10);
        step();
        ena = 1'b0;
        chk("stream e3 d1", data_out1, 32'h12);
        chk("stream e3 v2", {31'd0, rd_valid2}, 32'd1);
        chk("stream e3 d2", data_out2, 32'h11);
        step();
        rena = 1'b0;
        chk("stream e4 v1", {31'd0, rd_valid1}, 32'd0);
        chk("stream e4 v2", {31'd0, rd_valid2}, 32'd1);
        chk("stream e4 d2", data_out2, 32'h12);
        step();
        chk("stream e5 v2", {31'd0, rd_valid2}, 32'd0);
        chk("stream hold d2", data_out2, 32'h12);
        chk("stream hold d1", data_out1, 32'h12);

        // Reset with two reads in flight on the latency-2 instance
        ena = 1'b1; rena = 1'b1; raddr = 5'd5;
        step();
        raddr = 5'd0;
        step();
        rena = 1'b0;
        chk("inflight d2", data_out2, 32'hAA22_CC44);
        rst_n = 1'b0;
        #1;
        chk("midreset v", {30'd0, rd_valid1, rd_valid2}, 32'd0);
        chk("midreset d1", data_out1, 32'h0);
        chk("midreset d2", data_out2, 32'h0);
        chk("midreset busy", {30'd0, init_busy1, init_busy2}, 32'd3);
        step();
        step();
        rst_n = 1'b1;
        wait_init("resweep");
        do_read("resweep a5", 5'd5, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port synchronous RAM.
- Successor to the team's single-port 32x32 RAM, with:
  - independent write and read ports,
  - per-byte write enables,
  - configurable read latency (1 or 2),
  - write-first same-address bypass,
  - a post-reset clear sweep.
- Used as register-file and scratch storage in the CPU datapath and as backing store for buffer blocks.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W (localparam).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2. Any other value is an elaboration error.
- CLEAR_ON_RESET, 1, when 1 the memory is zero-filled by a sweep after reset.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; gates all new reads and writes.
- wena  input  1  write request.
- waddr  input  ADDR_W  write address.
- wbe  input  DATA_W/8  byte write enables; bit i covers data_in[8i+7:8i].
- data_in  input  DATA_W  write data.
- rena  input  1  read request.
- raddr  input  ADDR_W  read address.
- data_out  output  DATA_W  read data; registered.
- rd_valid  output  1  one-cycle pulse: data_out carries a read result.
- init_busy  output  1  high while the clear sweep runs; requests are ignored.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0, rd_valid=0, all read-pipeline registers and valid bits 0.
  - Sweep counter=0.
  - init_busy=CLEAR_ON_RESET; state=INIT if CLEAR_ON_RESET else READY.
  - Memory array itself has no async reset.
- FSM INIT:
  - Each cycle writes all-zero to mem[cnt], then cnt++.
  - After the cycle writing address DEPTH-1, next state is READY and init_busy falls.
  - INIT lasts exactly DEPTH cycles after reset release.
  - All wena/rena are ignored in INIT: no memory change, no rd_valid.
- FSM READY: terminal until the next reset.
  - With CLEAR_ON_RESET=0, memory contents after reset are undefined (X in simulation).
- Write: in READY with ena=1, wena=1 at a rising edge, mem[waddr] byte i takes data_in byte i for every wbe[i]=1. Other bytes are unchanged. wbe=0 is a legal no-op.
- Read acceptance: in READY with ena=1, rena=1 at a rising edge, the read is accepted.
  - Throughput: one read per cycle, back-to-back allowed.
- Read latency RD_LAT=1: data_out/rd_valid update at the same edge that accepts the read. Visible in the cycle after the request.
- Read latency RD_LAT=2: one extra register stage. Result and rd_valid appear one cycle later than with RD_LAT=1.
- rd_valid is high for exactly one cycle per accepted read.
- When rd_valid=0, data_out holds its last value.
- Same-cycle read and write to the same address (write-first): the read returns the merged word, i.e. data_in bytes where wbe=1 and old bytes elsewhere.
- Different addresses in the same cycle are independent.
- ena=0:
  - New reads and writes are blocked.
  - Already-accepted reads in the RD_LAT=2 pipeline still complete on schedule.
- Address range: DEPTH = 2**ADDR_W, so every address is valid; there is no wrap logic.
- Reset mid-operation:
  - In-flight reads are discarded; rd_valid drops immediately.
  - The sweep restarts from 0, including when reset is asserted during INIT.

Test Plan:
- Clear sweep: release rst_n, defaults (DEPTH=32) -> init_busy high exactly 32 cycles. A read of addr 31 requested during INIT gives no rd_valid. A read of addr 31 after INIT returns 0x00000000 with rd_valid one cycle later.
- Byte enables: write 0xAABBCCDD to addr 5 with wbe=4'b1111, then 0x11223344 with wbe=4'b0101 -> read of addr 5 returns 0xAA22CC44.
- Write-first bypass: same cycle, write 0xDEADBEEF wbe=4'b1100 to addr 7 (old 0x01234567) and read addr 7 -> data_out=0xDEAD4567.
- Latency and streaming, RD_LAT=2: read addrs 0,1,2 on consecutive cycles (preloaded 0x10,0x11,0x12) -> rd_valid high on cycles 2,3,4 after the first request, with data 0x10,0x11,0x12. Set ena=0 after the last request -> the 0x12 result still arrives.
- Enable gating: ena=0 with wena=1, addr 3, data 0xFFFFFFFF -> later read of addr 3 returns the unchanged value. ena=0 with rena=1 -> no rd_valid.
- Reset mid-stream: assert rst_n=0 with 2 reads in flight (RD_LAT=2) -> rd_valid=0 and data_out=0 immediately. Sweep restarts; after 32 cycles a read of the previously written addr 5 returns 0.
